eeprom_save_ctrl: RTL and testbench

- Owns the 8 KiB backing RAM of the emulated serial EEPROM and arbitrates it between the serial protocol engine (byte port) and the host SD block interface.
- Sequences whole-image load from host media and sector-granular save of dirty 512-byte sectors back to host media.
- Sits between the cartridge EEPROM protocol logic and the top-level host SD/image interface.

---
 rtl/eeprom_save_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_eeprom_save_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_save_ctrl.sv
// Backing-RAM owner for the emulated serial EEPROM: arbitrates the 8 KiB RAM between the protocol
// engine and the host SD block port, loads the whole image and saves dirty sectors back.
// Optional build macro EEPROM_AUTOSAVE_EN adds an idle-timeout automatic save.
module eeprom_save_ctrl #(
  parameter int          SECTORS        = 16,
  parameter logic [23:0] AUTOSAVE_DELAY = 24'd4000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] eep_addr,
  input  logic        eep_re,
  input  logic        eep_we,
  input  logic [7:0]  eep_wdata,
  output logic        eep_ready,
  output logic [7:0]  eep_rdata,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        load_req,
  input  logic        save_req,
  output logic [3:0]  sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_XFER,
    S_LOAD_NEXT,
    S_SAVE_SCAN,
    S_SAVE_REQ,
    S_SAVE_XFER
  } state_t;

  localparam logic [3:0] LAST_SECTOR = 4'(SECTORS - 1);

  state_t             state_q, state_d;
  logic [3:0]         sector_q, sector_d;
  logic [SECTORS-1:0] dirty_q, dirty_d;
  logic               loaded_q, loaded_d;
  logic               load_pend_q, load_pend_d;
  logic               save_pend_q, save_pend_d;
  logic               rd_pend_q;
  logic               host_rd_q;
  logic [7:0]         eep_rdata_q;
  logic [7:0]         din_q;

  logic               load_seq;
  logic               host_wr;
  logic               host_rd;
  logic               eng_ok;
  logic               wr_acc;
  logic               rd_acc;
  logic               save_trig;
  logic               scan_hit;
  logic [3:0]         scan_idx;

  // Engine handshake: eep_re/eep_we are held until eep_ready=1; the strobe is consumed in that
  // cycle (write takes priority if both are high) and read data is on eep_rdata the cycle after.
  assign load_seq = (state_q == S_LOAD_REQ) || (state_q == S_LOAD_XFER) ||
                    (state_q == S_LOAD_NEXT);
  assign host_wr  = (state_q == S_LOAD_XFER) && sd_buff_wr;
  assign host_rd  = (state_q == S_SAVE_XFER) && sd_ack;
  assign eng_ok   = !load_seq && !host_rd;
  assign wr_acc   = eep_we && eng_ok;
  assign rd_acc   = eep_re && !eep_we && eng_ok && (state_q != S_SAVE_XFER);
  assign eep_ready = wr_acc || rd_acc;

`ifdef EEPROM_AUTOSAVE_EN
  logic [23:0] idle_cnt_q, idle_cnt_d;
  logic        auto_req;

  // Counts idle cycles with unsaved data; any accepted write restarts the wait.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    auto_req   = 1'b0;
    if (wr_acc) begin
      idle_cnt_d = '0;
    end else if ((state_q == S_IDLE) && (|dirty_q)) begin
      if (idle_cnt_q == AUTOSAVE_DELAY - 24'd1) begin
        auto_req   = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign save_trig = save_req || auto_req;
`else
  logic unused_autosave_delay;
  assign unused_autosave_delay = ^AUTOSAVE_DELAY;
  assign save_trig = save_req;
`endif

  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = SECTORS - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        scan_hit = 1'b1;
        scan_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sector_d    = sector_q;
    dirty_d     = dirty_q;
    loaded_d    = loaded_q;
    load_pend_d = load_pend_q;
    save_pend_d = save_pend_q;

    if (state_q != S_IDLE) begin
      if (load_req)  load_pend_d = 1'b1;
      if (save_trig) save_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (load_req || load_pend_q) begin
          state_d     = S_LOAD_REQ;
          sector_d    = '0;
          load_pend_d = 1'b0;
          if (save_trig) save_pend_d = 1'b1;
        end else if (save_trig || save_pend_q) begin
          state_d     = S_SAVE_SCAN;
          save_pend_d = 1'b0;
        end
      end
      S_LOAD_REQ: begin
        if (sd_ack) state_d = S_LOAD_XFER;
      end
      S_LOAD_XFER: begin
        if (!sd_ack) state_d = S_LOAD_NEXT;
      end
      S_LOAD_NEXT: begin
        if (sector_q == LAST_SECTOR) begin
          sector_d = '0;
          dirty_d  = '0;
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          sector_d = sector_q + 4'd1;
          state_d  = S_LOAD_REQ;
        end
      end
      S_SAVE_SCAN: begin
        if (scan_hit) begin
          sector_d = scan_idx;
          state_d  = S_SAVE_REQ;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SAVE_REQ: begin
        if (sd_ack) begin
          dirty_d[sector_q] = 1'b0;
          state_d           = S_SAVE_XFER;
        end
      end
      S_SAVE_XFER: begin
        if (!sd_ack) state_d = S_SAVE_SCAN;
      end
      default: state_d = S_IDLE;
    endcase

    // Applied last so a write landing on the sector being cleared keeps it dirty.
    if (wr_acc) dirty_d[eep_addr[12:9]] = 1'b1;
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (host_wr) begin
      mem_addr  = {sector_q, sd_buff_addr};
      mem_we    = 1'b1;
      mem_wdata = sd_buff_dout;
    end else if (host_rd) begin
      mem_addr  = {sector_q, sd_buff_addr};
    end else if (wr_acc) begin
      mem_addr  = eep_addr;
      mem_we    = 1'b1;
      mem_wdata = eep_wdata;
    end else if (rd_acc) begin
      mem_addr  = eep_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sector_q    <= '0;
      dirty_q     <= '0;
      loaded_q    <= 1'b0;
      load_pend_q <= 1'b0;
      save_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      host_rd_q   <= 1'b0;
      eep_rdata_q <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      sector_q    <= sector_d;
      dirty_q     <= dirty_d;
      loaded_q    <= loaded_d;
      load_pend_q <= load_pend_d;
      save_pend_q <= save_pend_d;
      rd_pend_q   <= rd_acc;
      host_rd_q   <= host_rd;
      if (rd_pend_q) eep_rdata_q <= mem_rdata;
      if (host_rd_q) din_q <= mem_rdata;
    end
  end

  // RAM data arrives one cycle after the address, so it is forwarded live and then held.
  assign eep_rdata   = rd_pend_q ? mem_rdata : eep_rdata_q;
  assign sd_buff_din = host_rd_q ? mem_rdata : din_q;
  assign sd_lba      = sector_q;
  assign sd_rd       = (state_q == S_LOAD_REQ);
  assign sd_wr       = (state_q == S_SAVE_REQ);
  assign busy        = (state_q != S_IDLE);
  assign loaded      = loaded_q;

endmodule

// File: tb/tb_eeprom_save_ctrl.sv
// Directed bench for eeprom_save_ctrl: behavioural RAM and host/engine driver tasks, a read-back
// vector table, and hand-written sequences for load, save, contention, reset and autosave.
module tb_eeprom_save_ctrl;

`ifdef EEPROM_AUTOSAVE_EN
  localparam logic [23:0] TB_DELAY = 24'd100;
`else
  localparam logic [23:0] TB_DELAY = 24'd4000000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] eep_addr;
  logic        eep_re, eep_we;
  logic [7:0]  eep_wdata;
  logic        eep_ready;
  logic [7:0]  eep_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        load_req, save_req;
  logic [3:0]  sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        busy, loaded;

  eeprom_save_ctrl #(.SECTORS(16), .AUTOSAVE_DELAY(TB_DELAY)) dut (
    .clk(clk), .reset(reset),
    .eep_addr(eep_addr), .eep_re(eep_re), .eep_we(eep_we), .eep_wdata(eep_wdata),
    .eep_ready(eep_ready), .eep_rdata(eep_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_req(load_req), .save_req(save_req),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .busy(busy), .loaded(loaded)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  logic [7:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_q[$];
  logic [7:0] save_buf [0:511];
  int         wr_rises = 0;
  logic       sd_wr_d = 1'b0;
  bit         load_watch = 1'b0;
  int         ready_in_load = 0;

  always @(negedge clk) begin
    if (sd_wr && !sd_wr_d) wr_rises++;
    sd_wr_d = sd_wr;
    if (load_watch && busy && eep_ready) ready_in_load++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input bit ld, input bit sv);
    load_req = ld;
    save_req = sv;
    tick(1);
    load_req = 1'b0;
    save_req = 1'b0;
  endtask

  // Host fills one sector with pattern byte = address[12:8] ^ address[7:0].
  task automatic host_load_sector(input logic [3:0] lba, input int nbytes);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = sd_rd;
    end
    if (!ok) begin
      check("load_sd_rd_timeout", 32'd0, 32'd1);
      return;
    end
    check("load_lba", 32'(sd_lba), 32'(lba));
    @(posedge clk);
    #1 sd_ack = 1'b1;
    tick(1);
    for (int k = 0; k < nbytes; k++) begin
      sd_buff_wr   = 1'b1;
      sd_buff_addr = 9'(k);
      sd_buff_dout = {lba, sd_buff_addr[8]} ^ sd_buff_addr[7:0];
      tick(1);
    end
    sd_buff_wr = 1'b0;
    if (nbytes == 512) sd_ack = 1'b0;
  endtask

  task automatic host_save();
    bit         ok = 1'b0;
    logic [3:0] lba;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = sd_wr;
    end
    if (!ok) begin
      check("save_sd_wr_timeout", 32'd0, 32'd1);
      return;
    end
    lba = sd_lba;
    if (exp_q.size() == 0) check("save_unexpected", 32'(lba), 32'hFF);
    else check("save_lba", 32'(lba), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1 sd_ack = 1'b1;
    sd_buff_addr = '0;
    tick(1);
    for (int k = 0; k <= 512; k++) begin
      if (k < 512) sd_buff_addr = 9'(k);
      @(negedge clk);
      if (k > 0) save_buf[k-1] = sd_buff_din;
      @(posedge clk);
      #1;
    end
    sd_ack = 1'b0;
  endtask

  task automatic eng_access(input bit wr, input logic [12:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output int waited, output logic ack_at);
    bit got = 1'b0;
    waited = 0;
    ack_at = 1'b1;
    rd = 8'h00;
    eep_addr = a;
    eep_wdata = d;
    eep_we = wr;
    eep_re = !wr;
    while (!got && waited < 3000) begin
      @(negedge clk);
      if (eep_ready) begin
        got = 1'b1;
        ack_at = sd_ack;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    eep_we = 1'b0;
    eep_re = 1'b0;
    if (!got) check("eng_timeout", 32'd0, 32'd1);
    if (!wr) begin
      @(negedge clk);
      rd = eep_rdata;
      @(posedge clk);
      #1;
    end
  endtask

  // Full image load with the engine holding a read strobe; busy pattern after the last sector
  // shows whether a pending save scan ran (LOAD_XFER, LOAD_NEXT, IDLE, [SAVE_SCAN], IDLE...).
  task automatic do_load(input bit with_save);
    logic [5:0] pat;
    ready_in_load = 0;
    load_watch = 1'b1;
    eep_addr = 13'h0000;
    eep_re = 1'b1;
    pulse_req(1'b1, with_save);
    for (int s = 0; s < 16; s++) host_load_sector(4'(s), 512);
    load_watch = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat[5-k] = busy;
      if (k < 2 && eep_ready) ready_in_load++;
      @(posedge clk);
      #1;
    end
    eep_re = 1'b0;
    check("load_ready_low", 32'(ready_in_load), 32'd0);
    check("load_busy_pattern", 32'(pat), with_save ? 32'b110100 : 32'b110000);
    check("load_loaded", 32'(loaded), 32'd1);
    check("load_busy_end", 32'(busy), 32'd0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [12:0] addr;
    logic [7:0]  exp;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] rd;
  int         e_wait;
  logic       e_ack;
  int         rises0;
  int         cnt;

  initial begin
    vecs[0] = '{13'h1203, 8'h11};
    vecs[1] = '{13'h0000, 8'h00};
    vecs[2] = '{13'h01FF, 8'hFE};
    vecs[3] = '{13'h1FFF, 8'hE0};
    vecs[4] = '{13'h0400, 8'h04};
    vecs[5] = '{13'h0A55, 8'h5F};

    reset = 1'b1;
    eep_addr = '0; eep_re = 1'b0; eep_we = 1'b0; eep_wdata = '0;
    load_req = 1'b0; save_req = 1'b0; sd_ack = 1'b0;
    sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_sd_rd_wr", {30'd0, sd_rd, sd_wr}, 32'd0);
    check("rst_sd_lba", 32'(sd_lba), 32'd0);
    check("rst_eep_ready", 32'(eep_ready), 32'd0);
    reset = 1'b0;
    tick(2);

    // Image load and read-back table
    do_load(1'b0);
    for (int i = 0; i < 6; i++) begin
      eng_access(1'b0, vecs[i].addr, 8'h00, rd, e_wait, e_ack);
      check($sformatf("vec_read_%0h", vecs[i].addr), 32'(rd), 32'(vecs[i].exp));
    end

    // Two dirty sectors saved in ascending order
    eng_access(1'b1, 13'h0400, 8'hA5, rd, e_wait, e_ack);
    eng_access(1'b1, 13'h1FFF, 8'hA5, rd, e_wait, e_ack);
    rises0 = wr_rises;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd15);
    pulse_req(1'b0, 1'b1);
    host_save();
    check("s2_byte0", 32'(save_buf[0]), 32'hA5);
    check("s2_byte3", 32'(save_buf[3]), 32'h07);
    host_save();
    check("s15_byte0", 32'(save_buf[0]), 32'h1E);
    check("s15_byte511", 32'(save_buf[511]), 32'hA5);
    tick(10);
    check("save_busy_end", 32'(busy), 32'd0);
    pulse_req(1'b0, 1'b1);
    tick(10);
    check("save_count_clean", 32'(wr_rises - rises0), 32'd2);

    // Engine write to the sector under transfer: stalls, then forces a re-save
    eng_access(1'b1, 13'h0400, 8'h5A, rd, e_wait, e_ack);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd2);
    pulse_req(1'b0, 1'b1);
    fork
      host_save();
      begin
        for (int i = 0; i < 400 && !sd_ack; i++) @(negedge clk);
        @(posedge clk);
        #1;
        tick(20);
        eng_access(1'b1, 13'h0401, 8'h3C, rd, e_wait, e_ack);
        check("xfer_write_after_host", 32'(e_ack), 32'd0);
        check("xfer_write_stalled", 32'(e_wait > 400), 32'd1);
      end
    join
    fork
      host_save();
      begin
        for (int i = 0; i < 400 && !sd_ack; i++) @(negedge clk);
        @(posedge clk);
        #1;
        tick(20);
        eng_access(1'b0, 13'h0401, 8'h00, rd, e_wait, e_ack);
        check("xfer_read_after_host", 32'(e_ack), 32'd0);
        check("xfer_read_data", 32'(rd), 32'h3C);
      end
    join
    check("resave_byte0", 32'(save_buf[0]), 32'h5A);
    check("resave_byte1", 32'(save_buf[1]), 32'h3C);
    tick(10);
    check("resave_queue_empty", 32'(exp_q.size()), 32'd0);
    check("resave_busy_end", 32'(busy), 32'd0);

    // Same-cycle load+save: load wins, then the scan finds nothing
    eng_access(1'b1, 13'h0A00, 8'h11, rd, e_wait, e_ack);
    rises0 = wr_rises;
    do_load(1'b1);
    check("both_no_save", 32'(wr_rises - rises0), 32'd0);
    eng_access(1'b0, 13'h0A00, 8'h00, rd, e_wait, e_ack);
    check("both_reloaded", 32'(rd), 32'h0A);

    // Reset in the middle of sector 3's transfer
    pulse_req(1'b1, 1'b0);
    for (int s = 0; s < 3; s++) host_load_sector(4'(s), 512);
    host_load_sector(4'd3, 100);
    #2 reset = 1'b1;
    #1;
    check("midrst_sd_rd", 32'(sd_rd), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_loaded", 32'(loaded), 32'd0);
    check("midrst_sd_lba", 32'(sd_lba), 32'd0);
    sd_ack = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    tick(2);
    do_load(1'b0);

    // Autosave after idle timeout
    rises0 = wr_rises;
    eng_access(1'b1, 13'h0000, 8'h77, rd, e_wait, e_ack);
`ifdef EEPROM_AUTOSAVE_EN
    cnt = 0;
    while (cnt < 300 && !sd_wr) begin
      @(negedge clk);
      cnt++;
    end
    check("autosave_delay_window", 32'(cnt >= 100 && cnt <= 104), 32'd1);
    exp_q.push_back(4'd0);
    host_save();
    check("autosave_byte0", 32'(save_buf[0]), 32'h77);
    tick(10);
    check("autosave_busy_end", 32'(busy), 32'd0);
`else
    cnt = 0;
    tick(150);
    check("no_autosave", 32'(wr_rises - rises0), 32'd0);
    check("no_autosave_busy", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
